// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Subtraction is A + ~B + 1, so the serial carry starts at one.
  localparam logic CARRY_INIT_SUB = 1'b1;

  // Bit counter width for a WIDTH-bit serial operation (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serial_subtractor_fa.sv
// Single-bit full adder cell used as the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and majority carry of the three inputs.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial A-B, LSB first, one bit per enabled clock, with valid/ready
// handshakes on operands and result.
module bit_serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 result bits need storing: the last bit comes straight
  // from the adder on the final edge.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             b_inv;
  logic             s;
  logic             carry_next;

  // Subtrahend bit is inverted into the adder.
  always_comb begin
    b_inv       = ~b_sr[0];
    res_next    = {s, res_sr};
    start_ready = (state == IDLE) & ena;
  end

  full_adder_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_inv),
    .cin (carry),
    .sum (s),
    .cout(carry_next)
  );

  // FSM, shift registers, counter, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            a_msb  <= a_in[WIDTH-1];
            b_msb  <= b_in[WIDTH-1];
            res_sr <= '0;
            carry  <= CARRY_INIT_SUB;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next[WIDTH-1:1];
          carry  <= carry_next;
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            diff      <= res_next;
            borrow    <= ~carry_next;
            ovf       <= (a_msb ^ b_msb) & (s ^ a_msb);
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench for bit_serial_subtractor (WIDTH=8).
module tb_bit_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] diff;
  logic       borrow;
  logic       ovf;

  int checks   = 0;
  int errors   = 0;
  int pushed   = 0;
  int received = 0;
  bit rnd_rr   = 0;

  logic [9:0] exp_q[$];

  bit_serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .diff       (diff),
    .borrow     (borrow),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    return {d, (a < b), ((a[7] != b[7]) && (d[7] != a[7]))};
  endfunction

  // Monitor: every accepted result is popped and compared.
  always @(negedge clk) begin
    if (rst_n && ena && res_valid && res_ready) begin
      received++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {22'd0, diff, borrow, ovf}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("result", {22'd0, diff, borrow, ovf}, {22'd0, e});
      end
    end
  end

  // Random result backpressure.
  always @(posedge clk) begin
    if (rnd_rr) begin
      #1 res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push,
                       input logic [9:0] exp);
    int n = 0;
    start_valid = 1'b1;
    a_in = a;
    b_in = b;
    @(negedge clk);
    while (!start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      start_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back(exp);
      pushed++;
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until res_valid is seen.
  task automatic wait_result(input string name, input int exp_edges);
    int n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      n++;
      if (res_valid) break;
    end
    chk(name, n, exp_edges);
  endtask

  initial begin
    logic [9:0] snap;
    int n;
    rst_n = 1'b0;
    ena = 1'b0;
    start_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    res_ready = 1'b0;
    #12;
    chk("reset_outputs", {22'd0, res_valid, diff, borrow, ovf}, 32'd0);
    chk("ready_ena_low", start_ready, 1'b0);
    ena = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", start_ready, 1'b1);

    // Directed vectors, hand-computed {diff, borrow, ovf}.
    res_ready = 1'b1;
    issue(8'h05, 8'h03, 1, {8'h02, 1'b0, 1'b0});
    wait_result("latency_basic", 8);
    issue(8'h03, 8'h05, 1, {8'hFE, 1'b1, 1'b0});
    wait_result("latency_2", 8);
    issue(8'h80, 8'h01, 1, {8'h7F, 1'b0, 1'b1});
    wait_result("latency_3", 8);
    issue(8'h7F, 8'hFF, 1, {8'h80, 1'b1, 1'b1});
    wait_result("latency_4", 8);
    step();

    // Backpressure: result held while res_ready low, no early accept.
    res_ready = 1'b0;
    issue(8'h80, 8'h01, 1, {8'h7F, 1'b0, 1'b1});
    wait_result("latency_bp", 8);
    snap = {diff, borrow, ovf};
    start_valid = 1'b1;
    a_in = 8'h10;
    b_in = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {21'd0, res_valid, diff, borrow, ovf}, {21'd0, 1'b1, snap});
      chk("bp_no_accept", start_ready, 1'b0);
    end
    res_ready = 1'b1;
    exp_q.push_back({8'h0F, 1'b0, 1'b0});
    pushed++;
    step();
    chk("bp_valid_drop", res_valid, 1'b0);
    chk("bp_ready_rise", start_ready, 1'b1);
    step();
    start_valid = 1'b0;
    wait_result("latency_after_bp", 8);
    step();

    // Clock-enable stall of three cycles after bit 3.
    issue(8'h5A, 8'hA5, 1, {8'hB5, 1'b1, 1'b1});
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      n++;
      if (n == 4) ena = 1'b0;
      if (n == 7) ena = 1'b1;
      if (res_valid) break;
    end
    chk("latency_stall", n, 11);
    step();

    // Asynchronous reset in mid-operation.
    issue(8'h33, 8'h11, 0, '0);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {22'd0, res_valid, diff, borrow, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ready_after_async", start_ready, 1'b1);
    issue(8'h05, 8'h03, 1, {8'h02, 1'b0, 1'b0});
    wait_result("latency_post_reset", 8);
    step();

    // Back-to-back stream with random result backpressure.
    rnd_rr = 1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      case (i)
        0: begin a = 8'h00; b = 8'hFF; end
        1: begin a = 8'hFF; b = 8'h00; end
        2: begin a = 8'h00; b = 8'h00; end
        3: begin a = 8'hFF; b = 8'hFF; end
        default: begin a = 8'($urandom); b = 8'($urandom); end
      endcase
      issue(a, b, 1, model(a, b));
      repeat ($urandom_range(0, 2)) step();
    end
    rnd_rr = 0;
    step();
    step();
    res_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);
    chk("result_count", received, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
